// File: rtl/shifter_pkg.sv
// Shared encodings and elaboration-time helpers for the pipelined log-shifter.
// Shift-amount levels are split evenly across register stages; trailing stages may own none.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFTOP_SLL = 2'b00,
    SHIFTOP_ROL = 2'b01,
    SHIFTOP_SRL = 2'b10,
    SHIFTOP_SRA = 2'b11
  } shiftop_e;

  function automatic int shamt_width(input int data_width);
    return $clog2(data_width);
  endfunction

  function automatic int levels_per_stage(input int data_width, input int stages);
    int l;
    l = $clog2(data_width);
    return (l + stages - 1) / stages;
  endfunction

  function automatic int stage_first_level(input int data_width, input int stages, input int k);
    int l;
    int f;
    l = $clog2(data_width);
    f = k * levels_per_stage(data_width, stages);
    return (f > l) ? l : f;
  endfunction

  // Number of levels owned by stage k; zero means the stage is a pure register.
  function automatic int stage_num_levels(input int data_width, input int stages, input int k);
    int l;
    int e;
    l = $clog2(data_width);
    e = (k + 1) * levels_per_stage(data_width, stages);
    if (e > l) e = l;
    return e - stage_first_level(data_width, stages, k);
  endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One register stage of the log-shifter: conditional power-of-two shifts for its levels,
// then a register that holds while the pipeline is stalled. Rotate only with SHIFTER_ROTATE_EN.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int SHAMT_W     = 5,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_hold,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  shiftop_e              i_op,
  input  logic [SHAMT_W-1:0]    i_b,
  input  logic                  i_sign,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output shiftop_e              o_op,
  output logic [SHAMT_W-1:0]    o_b,
  output logic                  o_sign,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  logic [DATA_WIDTH-1:0] w_data;
  logic [SHAMT_W-1:0]    w_rem;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  shiftop_e              r_op;
  logic [SHAMT_W-1:0]    r_b;
  logic                  r_sign;
  logic [TAG_WIDTH-1:0]  r_tag;

  // Shift-amount bits are consumed LSB-first so no variable bit-select is needed.
  always_comb begin
    int amt;
    amt    = 0;
    w_data = i_data;
    w_rem  = i_b >> FIRST_LEVEL;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      amt = 1 << (FIRST_LEVEL + l);
      if (w_rem[0]) begin
        case (i_op)
          SHIFTOP_SLL: w_data = w_data << amt;
          SHIFTOP_SRL: w_data = w_data >> amt;
          SHIFTOP_SRA: w_data = (w_data >> amt) | ({DATA_WIDTH{i_sign}} << (DATA_WIDTH - amt));
`ifdef SHIFTER_ROTATE_EN
          SHIFTOP_ROL: w_data = (w_data << amt) | (w_data >> (DATA_WIDTH - amt));
`endif
          default:     w_data = w_data;
        endcase
      end
      w_rem = w_rem >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_op    <= SHIFTOP_SLL;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_tag   <= '0;
    end else if (!i_hold) begin
      r_valid <= i_valid;
      r_data  <= w_data;
      r_op    <= i_op;
      r_b     <= i_b;
      r_sign  <= i_sign;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_op    = r_op;
  assign o_b     = r_b;
  assign o_sign  = r_sign;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA (+ rotate-left when SHIFTER_ROTATE_EN is defined) with valid/ready
// on both sides. The whole pipe freezes on output backpressure; the last stage is the output.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 5,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_A,
  input  logic [$clog2(DATA_WIDTH)-1:0] in_B,
  input  logic [1:0]                    in_Shiftop,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_Result,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          busy
);

  localparam int SHAMT_W = shamt_width(DATA_WIDTH);

  logic                  w_stall;
  logic                  w_accept;
  shiftop_e              w_in_op;
  logic [DATA_WIDTH-1:0] w_in_data;

  logic                  s_valid [STAGES];
  logic [DATA_WIDTH-1:0] s_data  [STAGES];
  shiftop_e              s_op    [STAGES];
  logic [SHAMT_W-1:0]    s_b     [STAGES];
  logic                  s_sign  [STAGES];
  logic [TAG_WIDTH-1:0]  s_tag   [STAGES];

  logic                  q_valid [STAGES];
  logic [DATA_WIDTH-1:0] q_data  [STAGES];
  shiftop_e              q_op    [STAGES];
  logic [SHAMT_W-1:0]    q_b     [STAGES];
  logic                  q_sign  [STAGES];
  logic [TAG_WIDTH-1:0]  q_tag   [STAGES];

  logic [STAGES-1:0]     w_valid_vec;
  logic                  w_unused_tail;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_in_op  = shiftop_e'(in_Shiftop);

`ifdef SHIFTER_ROTATE_EN
  assign w_in_data = in_A;
`else
  // Without rotate hardware a ROL request carries zero data, so every stage yields zero.
  assign w_in_data = (w_in_op == SHIFTOP_ROL) ? '0 : in_A;
`endif

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign s_valid[gi] = w_accept;
      assign s_data[gi]  = w_in_data;
      assign s_op[gi]    = w_in_op;
      assign s_b[gi]     = in_B;
      assign s_sign[gi]  = in_A[DATA_WIDTH-1];
      assign s_tag[gi]   = in_tag;
    end else begin : g_link
      assign s_valid[gi] = q_valid[gi-1];
      assign s_data[gi]  = q_data[gi-1];
      assign s_op[gi]    = q_op[gi-1];
      assign s_b[gi]     = q_b[gi-1];
      assign s_sign[gi]  = q_sign[gi-1];
      assign s_tag[gi]   = q_tag[gi-1];
    end

    shifter_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH),
      .SHAMT_W     (SHAMT_W),
      .FIRST_LEVEL (stage_first_level(DATA_WIDTH, STAGES, gi)),
      .NUM_LEVELS  (stage_num_levels(DATA_WIDTH, STAGES, gi))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_hold  (w_stall),
      .i_valid (s_valid[gi]),
      .i_data  (s_data[gi]),
      .i_op    (s_op[gi]),
      .i_b     (s_b[gi]),
      .i_sign  (s_sign[gi]),
      .i_tag   (s_tag[gi]),
      .o_valid (q_valid[gi]),
      .o_data  (q_data[gi]),
      .o_op    (q_op[gi]),
      .o_b     (q_b[gi]),
      .o_sign  (q_sign[gi]),
      .o_tag   (q_tag[gi])
    );

    assign w_valid_vec[gi] = q_valid[gi];
  end

  assign out_valid  = q_valid[STAGES-1];
  assign out_Result = q_data[STAGES-1];
  assign out_tag    = q_tag[STAGES-1];
  assign busy       = |w_valid_vec;

  assign w_unused_tail = ^{q_op[STAGES-1], q_b[STAGES-1], q_sign[STAGES-1]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomised and directed bench for pipelined_shifter; a queue-based model predicts each result.
// Define SHIFTER_ROTATE_EN for both bench and RTL to test the rotate build.
module tb_pipelined_shifter;

  localparam int DW = 32;
  localparam int ST = 5;
  localparam int TW = 4;
  localparam int BW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_A = '0;
  logic [BW-1:0] in_B = '0;
  logic [1:0]    in_Shiftop = 2'b00;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_Result;
  logic [TW-1:0] out_tag;
  logic          busy;

  always #5 clk = ~clk;

  pipelined_shifter #(.DATA_WIDTH(DW), .STAGES(ST), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_A       (in_A),
    .in_B       (in_B),
    .in_Shiftop (in_Shiftop),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_Result (out_Result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  int            pop_cyc_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            pop_cnt = 0;
  int            acc_cyc = 0;
  int            last_pop_cyc = 0;
  logic [DW-1:0] last_res = '0;
  logic [TW-1:0] last_tag = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] held_res = '0;
  logic [TW-1:0] held_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: the arithmetic definition of each shift mode.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a, input int b, input logic [1:0] op);
    logic [2*DW-1:0] ext;
    case (op)
      2'b00: return a << b;
      2'b10: return a >> b;
      2'b11: begin
        ext = {{DW{a[DW-1]}}, a} >> b;
        return ext[DW-1:0];
      end
      default: begin
`ifdef SHIFTER_ROTATE_EN
        if (b == 0) return a;
        return (a << b) | (a >> (DW - b));
`else
        return '0;
`endif
      end
    endcase
  endfunction

  // Single compare process: scoreboard, stall hold, handshake and busy on every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("in_ready_during_reset", in_ready, 1'b0);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", out_Result, held_res);
        check("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("result", out_Result, e.res);
          check("tag", out_tag, e.tag);
          $display("txn out tag=%0d result=%08h expected=%08h cycle=%0d", out_tag, out_Result, e.res, cyc);
          pop_cnt++;
          last_res     = out_Result;
          last_tag     = out_tag;
          last_pop_cyc = cyc;
          pop_cyc_q.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_res   = out_Result;
      held_tag   = out_tag;
      if (in_valid && in_ready) begin
        e.res = ref_shift(in_A, int'(in_B), in_Shiftop);
        e.tag = in_tag;
        exp_q.push_back(e);
        acc_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [BW-1:0] b, input logic [1:0] op,
                      input logic [TW-1:0] tag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_A = a; in_B = b; in_Shiftop = op; in_tag = tag;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_pending", exp_q.size(), 0);
    if (busy) check("drain_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // Single op into an empty pipe: literal result, tag and 5-cycle latency.
  task automatic directed(input string name, input logic [DW-1:0] a, input logic [BW-1:0] b,
                          input logic [1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] exp);
    int p0;
    int acc;
    wait_drain();
    p0 = pop_cnt;
    send(a, b, op, tag);
    acc = acc_cyc;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (pop_cnt != p0) break;
    end
    #1;
    if (pop_cnt == p0) check({name, "_timeout"}, pop_cnt, p0 + 1);
    else begin
      check({name, "_latency"}, last_pop_cyc - acc, ST);
      check({name, "_value"}, last_res, exp);
      check({name, "_tag"}, last_tag, tag);
    end
  endtask

  logic [DW-1:0] rol_exp;
  logic [DW-1:0] rol0_exp;
  bit            rnd_done;
  int            p0;

  initial begin
`ifdef SHIFTER_ROTATE_EN
    rol_exp  = 32'h0000_0003;
    rol0_exp = 32'hA5A5_1234;
`else
    rol_exp  = 32'h0000_0000;
    rol0_exp = 32'h0000_0000;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_result", out_Result, '0);
    check("reset_out_tag", out_tag, '0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1;

    directed("sll_b31", 32'h0000_0001, 5'd31, 2'b00, 4'd3, 32'h8000_0000);
    directed("sra_b4", 32'h8000_0000, 5'd4, 2'b11, 4'd1, 32'hF800_0000);
    directed("srl_b4", 32'hF000_000F, 5'd4, 2'b10, 4'd2, 32'h0F00_0000);
    directed("sra_pos_b31", 32'h7FFF_FFFF, 5'd31, 2'b11, 4'd4, 32'h0000_0000);
    directed("sra_neg_b31", 32'h8000_0000, 5'd31, 2'b11, 4'd5, 32'hFFFF_FFFF);
    directed("sll_b16", 32'hFFFF_FFFF, 5'd16, 2'b00, 4'd6, 32'hFFFF_0000);
    directed("sll_b0", 32'hA5A5_1234, 5'd0, 2'b00, 4'd7, 32'hA5A5_1234);
    directed("srl_b0", 32'hA5A5_1234, 5'd0, 2'b10, 4'd8, 32'hA5A5_1234);
    directed("sra_b0", 32'hA5A5_1234, 5'd0, 2'b11, 4'd9, 32'hA5A5_1234);
    directed("rol_b0", 32'hA5A5_1234, 5'd0, 2'b01, 4'd10, rol0_exp);
    directed("rol_b1", 32'h8000_0001, 5'd1, 2'b01, 4'd11, rol_exp);

    // Back-to-back: eight results on eight consecutive cycles.
    wait_drain();
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) send($urandom, BW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), TW'(i));
    wait_drain();
    check("b2b_count", pop_cyc_q.size(), 8);
    if (pop_cyc_q.size() == 8) check("b2b_span", pop_cyc_q[7] - pop_cyc_q[0], 7);

    // Backpressure from cycle 5 while eight ops are issued.
    p0 = pop_cnt;
    fork
      for (int i = 0; i < 8; i++) send($urandom, BW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), TW'(i + 8));
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", pop_cnt - p0, 8);

    // Reset with ops in flight: nothing may emerge afterwards.
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) send(32'h1234_5678, 5'd3, 2'b00, TW'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", out_Result, '0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_emit", pop_cnt - p0, 0);
    directed("post_reset_srl", 32'hDEAD_BEEF, 5'd8, 2'b10, 4'd12, 32'h00DE_ADBE);

    // Random traffic with random backpressure and gaps.
    rnd_done = 1'b0;
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [BW-1:0] b;
          case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 5'd31;
            default: b = BW'($urandom_range(0, 31));
          endcase
          send($urandom, b, 2'($urandom_range(0, 3)), TW'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("random_count", pop_cnt - p0, 300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
